// File: rtl/blvds_pkg.sv
// ============================================================================
// Module      : blvds_pkg
// Description : Constants, state type and bus-word helper shared by the
//               BLVDS transmitter and receiver. The CSUM state exists only
//               when BLVDS_TX_CHECKSUM_EN is defined.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package blvds_pkg;

  localparam logic [15:0] HEAD_WORD   = 16'h55AA;
  localparam logic [15:0] EPILOG_WORD = 16'hAA55;
  localparam logic [15:0] ABORT_WORD  = 16'hDEAD;

  localparam int FR_BIT = 17;
  localparam int DV_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEAD    = 3'd1,
    ST_PAYLOAD = 3'd2,
`ifdef BLVDS_TX_CHECKSUM_EN
    ST_CSUM    = 3'd3,
`endif
    ST_EPILOG  = 3'd4,
    ST_GAP     = 3'd5
  } tx_state_t;

  function automatic logic [17:0] bus_word(input logic i_fr, input logic i_dv,
                                           input logic [15:0] i_data);
    logic [17:0] w_word;
    w_word         = '0;
    w_word[FR_BIT] = i_fr;
    w_word[DV_BIT] = i_dv;
    w_word[15:0]   = i_data;
    return w_word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/blvds_tx_checksum.sv
// ============================================================================
// Module      : blvds_tx_checksum
// Description : Modulo-2^16 running sum of payload words. Compiled only when
//               BLVDS_TX_CHECKSUM_EN is defined.
// Revision    : 1.0
// ============================================================================
`default_nettype none

`ifdef BLVDS_TX_CHECKSUM_EN
module blvds_tx_checksum (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_acc,
  input  logic [15:0] i_data,
  output logic [15:0] o_sum
);

  logic [15:0] r_sum;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_sum <= '0;
    end else if (i_acc) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule
`endif

`default_nettype wire

// File: rtl/blvds_frame_transmitter.sv
// ============================================================================
// Module      : blvds_frame_transmitter
// Description : Drains a normal-mode FIFO into header/payload/epilog frames on
//               the 18-bit BLVDS bus. Optional checksum word enabled by
//               BLVDS_TX_CHECKSUM_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module blvds_frame_transmitter
  import blvds_pkg::*;
#(
  parameter logic [8:0] FRAME_LEN   = 9'd256,
  parameter logic [7:0] FRAME_DELAY = 8'd100,
  parameter logic [7:0] STALL_LIMIT = 8'd100
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic [15:0] iFIFO_DATA,
  input  logic        iFIFO_EMPTY,
  input  logic [8:0]  iUSEDW,
  output logic        oRD_REQ,
  output logic [17:0] oDATA_BLVDS,
  output logic        oBUSY,
  output logic        oSEND_DONE,
  output logic        oSTART_REJECT,
  output logic        oUNDERRUN
);

  tx_state_t   r_state;
  logic [8:0]  r_req_cnt;
  logic [8:0]  r_word_cnt;
  logic [7:0]  r_stall_cnt;
  logic [7:0]  r_gap_cnt;
  logic        r_rd_req;
  logic        r_q_valid;
  logic        r_done_pend;
  logic [17:0] r_bus;
  logic        r_busy;
  logic        r_done;
  logic        r_reject;
  logic        r_underrun;

  logic        w_start_ok;
  logic        w_can_read;
  logic        w_last_word;
  tx_state_t   w_after_payload;
  tx_state_t   w_end_state;

  assign w_start_ok  = (iUSEDW >= FRAME_LEN);
  // A read already in flight consumes the last visible word, so a second
  // back-to-back read needs at least two words present.
  assign w_can_read  = !iFIFO_EMPTY && (r_req_cnt < FRAME_LEN) &&
                       !(r_rd_req && (iUSEDW <= 9'd1));
  assign w_last_word = (r_word_cnt == FRAME_LEN - 9'd1);
  assign w_end_state = (FRAME_DELAY == 8'd0) ? ST_IDLE : ST_GAP;

`ifdef BLVDS_TX_CHECKSUM_EN
  logic [15:0] w_csum;

  assign w_after_payload = ST_CSUM;

  blvds_tx_checksum u_checksum (
    .i_clk   (iCLK),
    .i_rst   (iRST),
    .i_clear (r_state == ST_IDLE),
    .i_acc   ((r_state == ST_PAYLOAD) && r_q_valid),
    .i_data  (iFIFO_DATA),
    .o_sum   (w_csum)
  );
`else
  assign w_after_payload = ST_EPILOG;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state     <= ST_IDLE;
      r_req_cnt   <= '0;
      r_word_cnt  <= '0;
      r_stall_cnt <= '0;
      r_gap_cnt   <= '0;
      r_rd_req    <= 1'b0;
      r_q_valid   <= 1'b0;
      r_done_pend <= 1'b0;
      r_bus       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_reject    <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_done      <= r_done_pend;
      r_done_pend <= 1'b0;
      r_reject    <= 1'b0;
      r_underrun  <= 1'b0;
      r_q_valid   <= r_rd_req;

      case (r_state)
        ST_IDLE: begin
          r_bus       <= '0;
          r_rd_req    <= 1'b0;
          r_req_cnt   <= '0;
          r_word_cnt  <= '0;
          r_stall_cnt <= '0;
          r_gap_cnt   <= '0;
          if (iSTART) begin
            if (w_start_ok) begin
              // Prefetch word 0 now so it lands right behind the header.
              r_state   <= ST_HEAD;
              r_busy    <= 1'b1;
              r_rd_req  <= !iFIFO_EMPTY;
              r_req_cnt <= iFIFO_EMPTY ? 9'd0 : 9'd1;
            end else begin
              r_reject <= 1'b1;
            end
          end
        end

        ST_HEAD: begin
          r_bus    <= bus_word(1'b1, 1'b1, HEAD_WORD);
          r_state  <= ST_PAYLOAD;
          r_rd_req <= w_can_read;
          if (w_can_read) begin
            r_req_cnt <= r_req_cnt + 9'd1;
          end
        end

        ST_PAYLOAD: begin
          r_rd_req <= w_can_read;
          if (w_can_read) begin
            r_req_cnt <= r_req_cnt + 9'd1;
          end
          if (r_q_valid) begin
            r_bus       <= bus_word(1'b1, 1'b1, iFIFO_DATA);
            r_stall_cnt <= '0;
            if (w_last_word) begin
              r_state <= w_after_payload;
            end else begin
              r_word_cnt <= r_word_cnt + 9'd1;
            end
          end else if (r_stall_cnt == STALL_LIMIT) begin
            r_bus      <= bus_word(1'b1, 1'b1, ABORT_WORD);
            r_underrun <= 1'b1;
            r_rd_req   <= 1'b0;
            r_gap_cnt  <= '0;
            r_state    <= w_end_state;
            r_busy     <= (FRAME_DELAY != 8'd0);
          end else begin
            r_bus       <= bus_word(1'b1, 1'b0, 16'h0000);
            r_stall_cnt <= r_stall_cnt + 8'd1;
          end
        end

`ifdef BLVDS_TX_CHECKSUM_EN
        ST_CSUM: begin
          r_bus    <= bus_word(1'b1, 1'b1, w_csum);
          r_rd_req <= 1'b0;
          r_state  <= ST_EPILOG;
        end
`endif

        ST_EPILOG: begin
          r_bus       <= bus_word(1'b1, 1'b1, EPILOG_WORD);
          r_rd_req    <= 1'b0;
          r_done_pend <= 1'b1;
          r_gap_cnt   <= '0;
          r_state     <= w_end_state;
          r_busy      <= (FRAME_DELAY != 8'd0);
        end

        ST_GAP: begin
          r_bus    <= '0;
          r_rd_req <= 1'b0;
          if (r_gap_cnt == FRAME_DELAY - 8'd1) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_bus    <= '0;
          r_rd_req <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign oRD_REQ       = r_rd_req;
  assign oDATA_BLVDS   = r_bus;
  assign oBUSY         = r_busy;
  assign oSEND_DONE    = r_done;
  assign oSTART_REJECT = r_reject;
  assign oUNDERRUN     = r_underrun;

endmodule

`default_nettype wire
